// File: rtl/triangle_pkg.sv
// Shared constants, types and the fixed triangle job table for the job sequencer.
package triangle_pkg;

   localparam int COORD_W     = 3;
   localparam int NUM_JOBS    = 4;
   localparam int FIFO_DEPTH  = 16;
   localparam int ARM_TIMEOUT = 8;

   localparam int JOB_W = $clog2(NUM_JOBS);
   localparam int TMO_W = $clog2(ARM_TIMEOUT);
   localparam int PT_W  = 2 * COORD_W;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
   } vertex_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_V0    = 3'd1,
      ST_V1    = 3'd2,
      ST_V2    = 3'd3,
      ST_ARM   = 3'd4,
      ST_RUN   = 3'd5,
      ST_DRAIN = 3'd6,
      ST_DONE  = 3'd7
   } state_t;

   // Job table lookup: three vertices per job; vertex index 3 is unused and returns origin.
   function automatic vertex_t job_vertex(input logic [JOB_W-1:0] job, input logic [1:0] vtx);
      vertex_t v;
      case ({job, vtx})
         4'b00_00: v = '{x: 3'd0, y: 3'd0};
         4'b00_01: v = '{x: 3'd0, y: 3'd2};
         4'b00_10: v = '{x: 3'd2, y: 3'd0};
         4'b01_00: v = '{x: 3'd1, y: 3'd1};
         4'b01_01: v = '{x: 3'd5, y: 3'd1};
         4'b01_10: v = '{x: 3'd3, y: 3'd6};
         4'b10_00: v = '{x: 3'd7, y: 3'd0};
         4'b10_01: v = '{x: 3'd7, y: 3'd7};
         4'b10_10: v = '{x: 3'd0, y: 3'd7};
         4'b11_00: v = '{x: 3'd2, y: 3'd3};
         4'b11_01: v = '{x: 3'd6, y: 3'd5};
         4'b11_10: v = '{x: 3'd4, y: 3'd1};
         default:  v = '{x: 3'd0, y: 3'd0};
      endcase
      return v;
   endfunction

endpackage

// File: rtl/point_fifo.sv
// Synchronous point buffer. A push on a full FIFO is accepted only when a pop
// happens in the same cycle; otherwise it is discarded (the caller flags it).
module point_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW:0]      wr_ptr_r;
   logic [AW:0]      rd_ptr_r;
   logic             wr_en_s;
   logic             rd_en_s;

   assign empty   = (wr_ptr_r == rd_ptr_r);
   assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign rd_en_s = pop && !empty;
   assign wr_en_s = push && (!full || rd_en_s);
   assign head    = mem_r[rd_ptr_r[AW-1:0]];

   // Storage write; contents need no reset since the pointers define validity.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= push_data;
      end
   end

   // Read/write pointers with one wrap bit to distinguish full from empty.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (wr_en_s) begin
            wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
         end
         if (rd_en_s) begin
            rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
         end
      end
   end

endmodule

// File: rtl/triangle_job_sequencer.sv
// Feeds the fixed triangle job table into the point engine, buffers every emitted
// point for the display side, and only moves to the next job once the buffer drains.
module triangle_job_sequencer
   import triangle_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               tri_busy,
   input  logic               tri_po,
   input  logic [COORD_W-1:0] tri_xo,
   input  logic [COORD_W-1:0] tri_yo,
   output logic               tri_nt,
   output logic [COORD_W-1:0] tri_xi,
   output logic [COORD_W-1:0] tri_yi,
   output logic               pt_valid,
   output logic [COORD_W-1:0] pt_x,
   output logic [COORD_W-1:0] pt_y,
   input  logic               pt_next,
   output logic [JOB_W-1:0]   job_idx,
   output logic [7:0]         pt_count,
   output logic               done,
   output logic               overflow
);

   state_t             state_r;
   state_t             state_next_s;
   logic [TMO_W-1:0]   tmo_cnt_r;
   logic [JOB_W-1:0]   job_idx_r;
   logic [JOB_W-1:0]   job_next_s;
   logic [7:0]         pt_count_r;
   logic               overflow_r;
   logic               tri_nt_r;
   logic [COORD_W-1:0] tri_xi_r;
   logic [COORD_W-1:0] tri_yi_r;
   logic               done_r;
   vertex_t            vtx_next_s;

   logic               capture_s;
   logic               push_s;
   logic               pop_s;
   logic               start_ok_s;
   logic               last_job_s;
   logic               tmo_hit_s;
   logic               fifo_full_s;
   logic               fifo_empty_s;
   logic [PT_W-1:0]    head_s;

   assign capture_s  = (state_r == ST_ARM) || (state_r == ST_RUN) || (state_r == ST_DRAIN);
   assign push_s     = capture_s && tri_po;
   assign pop_s      = pt_next && !fifo_empty_s;
   assign start_ok_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
   assign last_job_s = (job_idx_r == JOB_W'(NUM_JOBS - 1));
   assign tmo_hit_s  = (tmo_cnt_r == TMO_W'(ARM_TIMEOUT - 1));

   point_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (PT_W)
   ) u_point_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_s),
      .push_data ({tri_xo, tri_yo}),
      .pop       (pop_s),
      .head      (head_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s)
   );

   // Job sequencing next-state logic.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (start) state_next_s = ST_V0;
            else       state_next_s = state_r;
         end
         ST_V0: state_next_s = ST_V1;
         ST_V1: state_next_s = ST_V2;
         ST_V2: state_next_s = ST_ARM;
         ST_ARM: begin
            if (tri_busy)       state_next_s = ST_RUN;
            else if (tmo_hit_s) state_next_s = ST_DRAIN;
            else                state_next_s = ST_ARM;
         end
         ST_RUN: begin
            if (!tri_busy) state_next_s = ST_DRAIN;
            else           state_next_s = ST_RUN;
         end
         ST_DRAIN: begin
            if (fifo_empty_s) begin
               if (last_job_s) state_next_s = ST_DONE;
               else            state_next_s = ST_V0;
            end else begin
               state_next_s = ST_DRAIN;
            end
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   // Job index for the coming cycle: restart at 0, advance when a drained job hands over.
   always_comb begin
      job_next_s = job_idx_r;
      if (start_ok_s) begin
         job_next_s = '0;
      end else if ((state_r == ST_DRAIN) && (state_next_s == ST_V0)) begin
         job_next_s = job_idx_r + JOB_W'(1);
      end else begin
         job_next_s = job_idx_r;
      end
   end

   // Vertex to present next cycle; zero outside the three vertex states.
   always_comb begin
      vtx_next_s = '0;
      case (state_next_s)
         ST_V0:   vtx_next_s = job_vertex(job_next_s, 2'd0);
         ST_V1:   vtx_next_s = job_vertex(job_next_s, 2'd1);
         ST_V2:   vtx_next_s = job_vertex(job_next_s, 2'd2);
         default: vtx_next_s = '0;
      endcase
   end

   // State, job index, arm timeout and registered engine/status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         job_idx_r <= '0;
         tmo_cnt_r <= '0;
         tri_nt_r  <= 1'b0;
         tri_xi_r  <= '0;
         tri_yi_r  <= '0;
         done_r    <= 1'b0;
      end else begin
         state_r   <= state_next_s;
         job_idx_r <= job_next_s;
         tmo_cnt_r <= ((state_r == ST_ARM) && (state_next_s == ST_ARM)) ? tmo_cnt_r + TMO_W'(1) : '0;
         tri_nt_r  <= (state_next_s == ST_V0);
         tri_xi_r  <= vtx_next_s.x;
         tri_yi_r  <= vtx_next_s.y;
         done_r    <= (state_next_s == ST_DONE);
      end
   end

   // Per-job captured point count, cleared on entry to a job's first vertex, saturating.
   always_ff @(posedge clk) begin
      if (reset) begin
         pt_count_r <= 8'd0;
      end else if ((state_next_s == ST_V0) && (state_r != ST_V0)) begin
         pt_count_r <= 8'd0;
      end else if (push_s && (pt_count_r != 8'hFF)) begin
         pt_count_r <= pt_count_r + 8'd1;
      end else begin
         pt_count_r <= pt_count_r;
      end
   end

   // Sticky drop flag: a point arrived on a full buffer with no pop to make room.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow_r <= 1'b0;
      end else if (start_ok_s) begin
         overflow_r <= 1'b0;
      end else if (push_s && fifo_full_s && !pop_s) begin
         overflow_r <= 1'b1;
      end else begin
         overflow_r <= overflow_r;
      end
   end

   assign tri_nt   = tri_nt_r;
   assign tri_xi   = tri_xi_r;
   assign tri_yi   = tri_yi_r;
   assign job_idx  = job_idx_r;
   assign pt_count = pt_count_r;
   assign done     = done_r;
   assign overflow = overflow_r;
   assign pt_valid = !fifo_empty_s;
   assign pt_x     = fifo_empty_s ? '0 : head_s[PT_W-1 -: COORD_W];
   assign pt_y     = fifo_empty_s ? '0 : head_s[COORD_W-1:0];

endmodule

// File: tb/tb_triangle_job_sequencer.sv
// Randomized bench for the triangle job sequencer with a behavioural engine and
// a queue-based reference for the point buffer, job order and status flags.
module tb_triangle_job_sequencer;
   import triangle_pkg::*;

   logic               clk = 1'b0;
   logic               reset, start, tri_busy, tri_po, pt_next;
   logic [COORD_W-1:0] tri_xo, tri_yo, tri_xi, tri_yi, pt_x, pt_y;
   logic               tri_nt, pt_valid, done, overflow;
   logic [JOB_W-1:0]   job_idx;
   logic [7:0]         pt_count;

   always #5 clk = ~clk;

   triangle_job_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .tri_busy(tri_busy), .tri_po(tri_po),
      .tri_xo(tri_xo), .tri_yo(tri_yo), .tri_nt(tri_nt), .tri_xi(tri_xi), .tri_yi(tri_yi),
      .pt_valid(pt_valid), .pt_x(pt_x), .pt_y(pt_y), .pt_next(pt_next), .job_idx(job_idx),
      .pt_count(pt_count), .done(done), .overflow(overflow)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   int job_x [NUM_JOBS][3] = '{'{0, 0, 2}, '{1, 5, 3}, '{7, 7, 0}, '{2, 6, 4}};
   int job_y [NUM_JOBS][3] = '{'{0, 2, 0}, '{1, 1, 6}, '{0, 7, 7}, '{3, 5, 1}};

   // reference state
   int q_x[$];
   int q_y[$];
   bit m_ovf      = 1'b0;
   bit seq_idle   = 1'b1;
   bit run_done   = 1'b0;
   bit stray      = 1'b0;
   bit prev_done  = 1'b0;
   int cur_job    = -1;
   int vphase     = 0;
   int eng_state  = 0;   // 0 idle, 1 starts next cycle, 2 emitting
   int eng_left   = 0;
   int emitted    = 0;
   int v2_cyc     = 0;
   int cyc        = 0;
   int prev_ptc   = 0;
   int n_pts   [NUM_JOBS];
   int hold_n  [NUM_JOBS];
   bit rnd_pop [NUM_JOBS];
   int job_cnt [NUM_JOBS];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic close_job();
      if (cur_job >= 0) begin
         check_eq("pt_count_final", prev_ptc, (job_cnt[cur_job] > 255) ? 255 : job_cnt[cur_job]);
         if (n_pts[cur_job] == 0) check_eq("arm_timeout_gap", cyc - v2_cyc, 10);
      end
   endtask

   task automatic check_idle(input string tag);
      check_eq({tag, "_pt_valid"}, pt_valid, 0);
      check_eq({tag, "_done"}, done, 0);
      check_eq({tag, "_job_idx"}, job_idx, 0);
      check_eq({tag, "_tri_nt"}, tri_nt, 0);
      check_eq({tag, "_tri_xi"}, tri_xi, 0);
      check_eq({tag, "_tri_yi"}, tri_yi, 0);
      check_eq({tag, "_pt_count"}, pt_count, 0);
      check_eq({tag, "_overflow"}, overflow, 0);
      check_eq({tag, "_pt_x"}, pt_x, 0);
   endtask

   // One cycle: check outputs at the negedge, then drive inputs and advance the reference.
   task automatic step(input bit st, input bit rs);
      bit emit;
      int cj;
      @(negedge clk);
      cyc++;
      check_eq("pt_valid", pt_valid, q_x.size() != 0);
      if (q_x.size() != 0) begin
         check_eq("pt_x_order", pt_x, q_x[0]);
         check_eq("pt_y_order", pt_y, q_y[0]);
      end
      check_eq("overflow", overflow, m_ovf);
      if (tri_nt) begin
         check_eq("nt_while_busy", tri_busy, 0);
         close_job();
         cur_job++;
         if (cur_job < NUM_JOBS) begin
            check_eq("job_idx", job_idx, cur_job);
            check_eq("done_during_job", done, 0);
            check_eq("v0_x", tri_xi, job_x[cur_job][0]);
            check_eq("v0_y", tri_yi, job_y[cur_job][0]);
            job_cnt[cur_job] = 0;
            vphase = 1;
         end else begin
            check_eq("extra_job", cur_job, NUM_JOBS - 1);
            cur_job = NUM_JOBS - 1;
            vphase  = 0;
         end
      end else if (vphase == 1) begin
         check_eq("v1_x", tri_xi, job_x[cur_job][1]);
         check_eq("v1_y", tri_yi, job_y[cur_job][1]);
         vphase = 2;
      end else if (vphase == 2) begin
         check_eq("v2_x", tri_xi, job_x[cur_job][2]);
         check_eq("v2_y", tri_yi, job_y[cur_job][2]);
         vphase    = 0;
         v2_cyc    = cyc;
         eng_state = 1;
         eng_left  = n_pts[cur_job];
         emitted   = 0;
      end else begin
         check_eq("idle_xi", tri_xi, 0);
         check_eq("idle_yi", tri_yi, 0);
      end
      if (done && !prev_done) begin
         check_eq("done_after_all_jobs", cur_job, NUM_JOBS - 1);
         close_job();
         cur_job  = -1;
         run_done = 1'b1;
         seq_idle = 1'b1;
      end
      prev_ptc  = pt_count;
      prev_done = done;

      // engine model and pop policy
      cj   = (cur_job >= 0) ? cur_job : 0;
      emit = (eng_state == 2) && (eng_left > 0);
      if (emit && (emitted < hold_n[cj])) pt_next = 1'b0;
      else if (rnd_pop[cj])               pt_next = 1'($urandom_range(0, 1));
      else                                pt_next = 1'b1;
      if (emit) begin
         tri_busy = 1'b1;
         tri_po   = 1'b1;
         tri_xo   = COORD_W'($urandom_range(0, 7));
         tri_yo   = COORD_W'($urandom_range(0, 7));
         eng_left--;
         emitted++;
      end else begin
         tri_busy = 1'b0;
         tri_po   = 1'b0;
         tri_xo   = '0;
         tri_yo   = '0;
         if (eng_state == 2) eng_state = 0;
      end
      if (eng_state == 1) eng_state = 2;

      if (rs) begin
         q_x.delete(); q_y.delete();
         m_ovf = 1'b0; cur_job = -1; vphase = 0; eng_state = 0;
         run_done = 1'b0; seq_idle = 1'b1;
         tri_busy = 1'b0; tri_po = 1'b0;
      end else begin
         if (pt_next && q_x.size() > 0) begin
            void'(q_x.pop_front());
            void'(q_y.pop_front());
         end
         if (tri_po) begin
            if (q_x.size() < FIFO_DEPTH) begin
               q_x.push_back(int'(tri_xo));
               q_y.push_back(int'(tri_yo));
            end else begin
               m_ovf = 1'b1;
            end
            if (job_cnt[cj] < 255) job_cnt[cj]++;
         end
         if (st && seq_idle) begin
            m_ovf = 1'b0; cur_job = -1; run_done = 1'b0; seq_idle = 1'b0;
         end
      end
      start = st;
      reset = rs;
   endtask

   task automatic run_until_done(input int max_cyc);
      int n;
      n = 0;
      while (!run_done && n < max_cyc) begin
         step(stray && ($urandom_range(0, 7) == 0), 1'b0);
         n++;
      end
      check_eq("run_completes", run_done, 1);
   endtask

   initial begin
      int guard;
      reset = 1'b1; start = 1'b0; pt_next = 1'b0;
      tri_busy = 1'b0; tri_po = 1'b0; tri_xo = '0; tri_yo = '0;
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      check_idle("reset");

      // Run A: 6 points with pops, empty job, overflow job, full push+pop job
      n_pts[0] = 6;  hold_n[0] = 0;   rnd_pop[0] = 1'b0;
      n_pts[1] = 0;  hold_n[1] = 0;   rnd_pop[1] = 1'b0;
      n_pts[2] = 20; hold_n[2] = 255; rnd_pop[2] = 1'b0;
      n_pts[3] = 20; hold_n[3] = 16;  rnd_pop[3] = 1'b0;
      step(1'b1, 1'b0);
      run_until_done(600);
      check_eq("overflow_after_drop", overflow, 1);
      step(1'b0, 1'b0);
      check_eq("done_holds", done, 1);
      check_eq("job_idx_at_done", job_idx, NUM_JOBS - 1);

      // Run B: restart from DONE, full buffer with simultaneous push/pop, stray starts
      n_pts[0] = 20;                       hold_n[0] = 16; rnd_pop[0] = 1'b0;
      n_pts[1] = $urandom_range(1, 12);    hold_n[1] = 0;  rnd_pop[1] = 1'b1;
      n_pts[2] = 0;                        hold_n[2] = 0;  rnd_pop[2] = 1'b1;
      n_pts[3] = $urandom_range(0, 9);     hold_n[3] = 0;  rnd_pop[3] = 1'b1;
      step(1'b1, 1'b0);
      stray = 1'b1;
      run_until_done(800);
      stray = 1'b0;
      check_eq("overflow_full_pushpop", overflow, 0);

      // Run C: reset in the middle of RUN, then a full random run
      n_pts[0] = 10; hold_n[0] = 0; rnd_pop[0] = 1'b0;
      step(1'b1, 1'b0);
      guard = 0;
      while (!(eng_state == 2 && emitted >= 3) && guard < 50) begin
         step(1'b0, 1'b0);
         guard++;
      end
      check_eq("reached_run", emitted >= 3, 1);
      step(1'b0, 1'b1);
      step(1'b0, 1'b0);
      check_idle("mid_reset");
      for (int j = 0; j < NUM_JOBS; j++) begin
         n_pts[j]   = $urandom_range(0, 18);
         hold_n[j]  = $urandom_range(0, 18);
         rnd_pop[j] = 1'($urandom_range(0, 1));
      end
      step(1'b1, 1'b0);
      run_until_done(800);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
